mem_loader: RTL

Byte-stream memory writer: accepts a valid/ready byte stream, packs bytes little-endian into 32-bit words and writes them to consecutive addresses of a synchronous-read word memory, the same word/address geometry our ROM/RAM blocks read back. It sits between a host byte source (UART/SPI command layer) and the write port of a dual-port word RAM, loading images that are later fetched 32 bits per cycle. A running 32-bit word sum is kept for host-side verification.

---
 rtl/mem_loader_pkg.sv | 15 +
 rtl/mem_loader_byte_packer.sv | 48 ++++
 rtl/mem_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared encodings and word geometry for the byte-stream memory loader.
package mem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = 32;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Little-endian byte packer: collects accepted bytes into 32-bit lanes and
// flags the byte that completes a word.
module byte_packer
  import mem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_full
);

  logic [BYTE_CNT_W-1:0]     byte_cnt_reg;
  logic [WORD_WIDTH-1:0]     lane_reg;
  logic [BYTES_PER_WORD-1:0] lane_hit;

  // word already carries the byte being accepted, so the completing byte
  // can be written out on the same edge that accepts it.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    assign lane_hit[gi]     = accept && (byte_cnt_reg == BYTE_CNT_W'(gi));
    assign word[gi*8 +: 8]  = lane_hit[gi] ? data : lane_reg[gi*8 +: 8];
  end

  assign word_full = accept && (byte_cnt_reg == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      byte_cnt_reg <= '0;
    end else if (clear) begin
      byte_cnt_reg <= '0;
    end else if (accept) begin
      byte_cnt_reg <= byte_cnt_reg + BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      lane_reg <= '0;
    end else begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (lane_hit[i]) lane_reg[i*8 +: 8] <= data;
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream memory writer: packs a valid/ready byte stream into 32-bit
// words written to consecutive RAM addresses, keeping a running word sum.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDRWIDTH = 8,
  parameter int WORDS     = 1 << ADDRWIDTH
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  start,
  input  logic [ADDRWIDTH-1:0]  base_addr,
  input  logic [ADDRWIDTH:0]    len,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDRWIDTH-1:0]  wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] sum
);

  state_t                state_reg, state_next;
  logic [ADDRWIDTH-1:0]  addr_reg;
  logic [ADDRWIDTH:0]    remaining_reg;
  logic [WORD_WIDTH-1:0] sum_reg;
  logic                  wr_en_reg;
  logic [ADDRWIDTH-1:0]  wr_addr_reg;
  logic [WORD_WIDTH-1:0] wr_data_reg;

  logic                  start_accept;
  logic                  byte_accept;
  logic [WORD_WIDTH-1:0] word;
  logic                  word_full;
  logic [ADDRWIDTH-1:0]  addr_inc;

  assign start_accept = (state_reg == ST_IDLE) && start;
  assign byte_accept  = in_valid && in_ready;
  assign addr_inc     = (addr_reg == ADDRWIDTH'(WORDS - 1)) ? '0 : addr_reg + ADDRWIDTH'(1);

  byte_packer u_packer (
    .clk       (clk),
    .reset_l   (reset_l),
    .clear     (start_accept),
    .accept    (byte_accept),
    .data      (in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = (len == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (word_full) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = (remaining_reg == '0) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The write is registered on the edge that accepts the 4th byte, so the
  // strobe, address and data all appear together in the WRITE cycle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      sum_reg       <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      wr_en_reg <= word_full;
      if (start_accept) begin
        addr_reg      <= base_addr;
        remaining_reg <= len;
        sum_reg       <= '0;
      end
      if (word_full) begin
        wr_addr_reg   <= addr_reg;
        wr_data_reg   <= word;
        sum_reg       <= sum_reg + word;
        addr_reg      <= addr_inc;
        remaining_reg <= remaining_reg - (ADDRWIDTH + 1)'(1);
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign sum     = sum_reg;

endmodule
